// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its prediction FIFO.
package branch_resolver_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PRED_BITS_W = 2;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_FLUSHING = 1'b1
    } state_e;

    // One in-flight prediction, captured at fetch.
    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic [INSTR_W-1:0]     instr;
        logic                   pred_taken;
        logic [PC_W-1:0]        pred_addr;
        logic [PRED_BITS_W-1:0] pred_bits;
    } entry_t;

    // Architecturally correct fetch address after the branch.
    function automatic logic [PC_W-1:0] actual_next_pc(input logic            taken,
                                                       input logic [PC_W-1:0] target,
                                                       input logic [PC_W-1:0] pc);
        return taken ? target : pc + PC_INC;
    endfunction

    // A taken branch that went to the wrong place counts as a mispredict too.
    function automatic logic is_mispredict(input entry_t          e,
                                           input logic            taken,
                                           input logic [PC_W-1:0] target);
        return (e.pred_taken != taken) || (taken && (e.pred_addr != target));
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/resolve inputs and flush/training/counter outputs of the branch resolver.
interface branch_resolver_if #(
    parameter int unsigned CNT_W = 32
);
    logic             Fetch_push;
    logic [31:0]      Fetch_PC;
    logic [31:0]      Fetch_instr;
    logic             Pred_taken;
    logic [31:0]      Pred_addr;
    logic [1:0]       Pred_bits;
    logic             Res_valid;
    logic             Res_taken;
    logic [31:0]      Res_target;

    logic             FLUSH;
    logic [31:0]      Redirect_PC;
    logic [31:0]      Branch_instr;
    logic [31:0]      Branch_addr;
    logic             Branch_resolved;
    logic [31:0]      Branch_resolved_addr;
    logic [1:0]       Branch_predictions;
    logic             Fifo_full;
    logic [CNT_W-1:0] Mispredict_count;
    logic [CNT_W-1:0] Branch_count;

    // Resolver side.
    modport slave (
        input  Fetch_push, Fetch_PC, Fetch_instr, Pred_taken, Pred_addr, Pred_bits,
               Res_valid, Res_taken, Res_target,
        output FLUSH, Redirect_PC, Branch_instr, Branch_addr, Branch_resolved,
               Branch_resolved_addr, Branch_predictions, Fifo_full,
               Mispredict_count, Branch_count
    );

    // Pipeline / predictor side.
    modport master (
        output Fetch_push, Fetch_PC, Fetch_instr, Pred_taken, Pred_addr, Pred_bits,
               Res_valid, Res_taken, Res_target,
        input  FLUSH, Redirect_PC, Branch_instr, Branch_addr, Branch_resolved,
               Branch_resolved_addr, Branch_predictions, Fifo_full,
               Mispredict_count, Branch_count
    );

endinterface

// File: rtl/branch_resolver_pred_fifo.sv
// In-flight prediction FIFO: synchronous clear, same-cycle push/pop, full/empty flags.
module branch_resolver_pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Accept handshakes and compute pointer/occupancy updates; clear wins over everything.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves in-flight branch predictions, raises FLUSH/redirect on mispredict,
// drives the predictor training bus and keeps saturating performance counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    branch_resolver_if.slave  br_io
);

    localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;

    logic [INSTR_W-1:0]     tr_instr_q;
    logic [PC_W-1:0]        tr_addr_q;
    logic                   tr_resolved_q;
    logic [PC_W-1:0]        tr_resolved_addr_q;
    logic [PRED_BITS_W-1:0] tr_bits_q;

    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

    entry_t          push_entry;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            running;
    logic            accept;
    logic            mispredict;
    logic [PC_W-1:0] next_pc;

    // Resolve acceptance and compare against the head prediction.
    always_comb begin
        running    = (state_q == ST_RUN);
        accept     = br_io.Res_valid && running && !fifo_empty;
        next_pc    = actual_next_pc(br_io.Res_taken, br_io.Res_target, head.pc);
        mispredict = accept && is_mispredict(head, br_io.Res_taken, br_io.Res_target);

        push_entry.pc         = br_io.Fetch_PC;
        push_entry.instr      = br_io.Fetch_instr;
        push_entry.pred_taken = br_io.Pred_taken;
        push_entry.pred_addr  = br_io.Pred_addr;
        push_entry.pred_bits  = br_io.Pred_bits;
    end

    // A mispredict clears the FIFO, which also discards any same-cycle push.
    branch_resolver_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .clear_i (mispredict),
        .push_i  (br_io.Fetch_push && running),
        .data_i  (push_entry),
        .pop_i   (accept),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FSM state register plus flush down-counter and captured redirect target.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            redirect_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redirect_q  <= redirect_d;
        end
    end

    // FSM next state: RUN -> FLUSHING on mispredict, back to RUN when the counter runs out.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        redirect_d  = redirect_q;
        unique case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d     = ST_FLUSHING;
                    flush_cnt_d = FlushLoad;
                    redirect_d  = next_pc;
                end
            end
            ST_FLUSHING: begin
                if (flush_cnt_q == '0) begin
                    state_d    = ST_RUN;
                    redirect_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: FLUSH and a redirect address that reads as zero outside the flush window.
    always_comb begin
        br_io.FLUSH       = (state_q == ST_FLUSHING);
        br_io.Redirect_PC = (state_q == ST_FLUSHING) ? redirect_q : '0;
        br_io.Fifo_full   = fifo_full;
    end

    // Saturating counter next values.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (accept && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Training bus registers (hold until the next resolve) and performance counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tr_instr_q         <= '0;
            tr_addr_q          <= '0;
            tr_resolved_q      <= 1'b0;
            tr_resolved_addr_q <= '0;
            tr_bits_q          <= '0;
            br_cnt_q           <= '0;
            mis_cnt_q          <= '0;
        end else begin
            if (accept) begin
                tr_instr_q         <= head.instr;
                tr_addr_q          <= head.pc;
                tr_resolved_q      <= br_io.Res_taken;
                tr_resolved_addr_q <= next_pc;
                tr_bits_q          <= head.pred_bits;
            end
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Drive registered training and counter values onto the bus.
    always_comb begin
        br_io.Branch_instr         = tr_instr_q;
        br_io.Branch_addr          = tr_addr_q;
        br_io.Branch_resolved      = tr_resolved_q;
        br_io.Branch_resolved_addr = tr_resolved_addr_q;
        br_io.Branch_predictions   = tr_bits_q;
        br_io.Mispredict_count     = mis_cnt_q;
        br_io.Branch_count         = br_cnt_q;
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based reference model.
module tb_branch_resolver;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned CNT_W        = 4;
    localparam int          CNT_MAX      = 15;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    branch_resolver_if #(.CNT_W(CNT_W)) bus ();

    branch_resolver #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .br_io (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
        logic [31:0] pa;
        logic [1:0]  pb;
    } ent_t;

    ent_t        mq[$];
    int          m_flush_left = 0;
    logic [31:0] m_redirect   = '0;
    logic [31:0] m_instr      = '0;
    logic [31:0] m_addr       = '0;
    logic        m_res        = 1'b0;
    logic [31:0] m_raddr      = '0;
    logic [1:0]  m_bits       = '0;
    int          m_mcnt       = 0;
    int          m_bcnt       = 0;

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_redirect   = '0;
        m_instr      = '0;
        m_addr       = '0;
        m_res        = 1'b0;
        m_raddr      = '0;
        m_bits       = '0;
        m_mcnt       = 0;
        m_bcnt       = 0;
    endtask

    // One clock edge of behaviour given the inputs that were presented.
    task automatic model_update(input logic push, input logic [31:0] pc, input logic [31:0] instr,
                                input logic pt, input logic [31:0] pa, input logic [1:0] pb,
                                input logic rv, input logic rt, input logic [31:0] rtgt);
        ent_t        h;
        ent_t        e;
        logic [31:0] nxt;
        bit          acc;
        bit          mis;
        bit          room;
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        room = (mq.size() < DEPTH);
        acc  = rv && (mq.size() > 0);
        mis  = 1'b0;
        if (acc) begin
            h       = mq.pop_front();
            nxt     = rt ? rtgt : h.pc + 32'd4;
            mis     = (h.pt != rt) || (rt && (h.pa != rtgt));
            m_instr = h.instr;
            m_addr  = h.pc;
            m_res   = rt;
            m_raddr = nxt;
            m_bits  = h.pb;
            if (m_bcnt < CNT_MAX) m_bcnt++;
            if (mis) begin
                if (m_mcnt < CNT_MAX) m_mcnt++;
                mq.delete();
                m_flush_left = FLUSH_CYCLES;
                m_redirect   = nxt;
            end
        end
        if (push && !mis && (room || acc)) begin
            e.pc = pc; e.instr = instr; e.pt = pt; e.pa = pa; e.pb = pb;
            mq.push_back(e);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            chk("flush",     32'(bus.FLUSH), 32'(m_flush_left > 0));
            chk("redirect",  bus.Redirect_PC, (m_flush_left > 0) ? m_redirect : 32'd0);
            chk("tr_instr",  bus.Branch_instr, m_instr);
            chk("tr_addr",   bus.Branch_addr, m_addr);
            chk("tr_res",    32'(bus.Branch_resolved), 32'(m_res));
            chk("tr_raddr",  bus.Branch_resolved_addr, m_raddr);
            chk("tr_bits",   32'(bus.Branch_predictions), 32'(m_bits));
            chk("fifo_full", 32'(bus.Fifo_full), 32'(mq.size() == DEPTH));
            chk("mis_cnt",   32'(bus.Mispredict_count), 32'(m_mcnt));
            chk("br_cnt",    32'(bus.Branch_count), 32'(m_bcnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present inputs, take one clock edge, advance the model, settle 1 time unit.
    task automatic step(input logic push, input logic [31:0] pc, input logic [31:0] instr,
                        input logic pt, input logic [31:0] pa, input logic [1:0] pb,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        bus.Fetch_push  = push;
        bus.Fetch_PC    = pc;
        bus.Fetch_instr = instr;
        bus.Pred_taken  = pt;
        bus.Pred_addr   = pa;
        bus.Pred_bits   = pb;
        bus.Res_valid   = rv;
        bus.Res_taken   = rt;
        bus.Res_target  = rtgt;
        @(posedge CLK);
        model_update(push, pc, instr, pt, pa, pb, rv, rt, rtgt);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] pa,
                        input logic [1:0] pb);
        step(1'b1, pc, pc ^ 32'hA5A5_0000, pt, pa, pb, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtgt);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1, rt, rtgt);
    endtask

    task automatic inputs_idle();
        bus.Fetch_push = 1'b0; bus.Fetch_PC = '0; bus.Fetch_instr = '0;
        bus.Pred_taken = 1'b0; bus.Pred_addr = '0; bus.Pred_bits = '0;
        bus.Res_valid  = 1'b0; bus.Res_taken = 1'b0; bus.Res_target = '0;
    endtask

    // Assert reset between edges (called just after a posedge), release mid-cycle, realign.
    task automatic pulse_reset();
        inputs_idle();
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        chk("rst_flush", 32'(bus.FLUSH), 32'd0);
        chk("rst_redir", bus.Redirect_PC, 32'd0);
        chk("rst_mcnt",  32'(bus.Mispredict_count), 32'd0);
        chk("rst_bcnt",  32'(bus.Branch_count), 32'd0);
        chk("rst_full",  32'(bus.Fifo_full), 32'd0);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        inputs_idle();
        #12;
        chk("rst0_addr", bus.Branch_addr, 32'd0);
        chk("rst0_bcnt", 32'(bus.Branch_count), 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Correct taken prediction.
        push(32'h100, 1'b1, 32'h200, 2'b10);
        resolve(1'b1, 32'h200);
        chk("ok_flush", 32'(bus.FLUSH), 32'd0);
        chk("ok_addr",  bus.Branch_addr, 32'h100);
        chk("ok_res",   32'(bus.Branch_resolved), 32'd1);
        chk("ok_raddr", bus.Branch_resolved_addr, 32'h200);
        chk("ok_bits",  32'(bus.Branch_predictions), 32'd2);
        chk("ok_bcnt",  32'(bus.Branch_count), 32'd1);

        // Direction mispredict: FLUSH for exactly two cycles.
        push(32'h40, 1'b1, 32'h80, 2'b01);
        resolve(1'b0, 32'h999);
        chk("dir_flush1", 32'(bus.FLUSH), 32'd1);
        chk("dir_redir",  bus.Redirect_PC, 32'h44);
        chk("dir_mcnt",   32'(bus.Mispredict_count), 32'd1);
        idle();
        chk("dir_flush2", 32'(bus.FLUSH), 32'd1);
        idle();
        chk("dir_flush3", 32'(bus.FLUSH), 32'd0);
        chk("dir_redir0", bus.Redirect_PC, 32'd0);

        // Target mispredict.
        push(32'h500, 1'b1, 32'h300, 2'b11);
        resolve(1'b1, 32'h380);
        chk("tgt_flush", 32'(bus.FLUSH), 32'd1);
        chk("tgt_redir", bus.Redirect_PC, 32'h380);
        idle();
        idle();

        // FIFO boundaries.
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 2'(i));
        chk("full4", 32'(bus.Fifo_full), 32'd1);
        push(32'h2000, 1'b0, 32'h0, 2'b00);
        chk("full5", 32'(bus.Fifo_full), 32'd1);
        step(1'b1, 32'h3000, 32'h3000, 1'b0, 32'h0, 2'b11, 1'b1, 1'b0, 32'h0);
        chk("pp_full", 32'(bus.Fifo_full), 32'd1);
        chk("pp_addr", bus.Branch_addr, 32'h1000);
        for (int i = 1; i < 4; i++) begin
            resolve(1'b0, 32'h0);
            chk("order", bus.Branch_addr, 32'h1000 + 32'(i * 4));
        end
        resolve(1'b0, 32'h0);
        chk("order_last", bus.Branch_addr, 32'h3000);
        resolve(1'b0, 32'h0);
        chk("empty_addr", bus.Branch_addr, 32'h3000);
        chk("empty_bcnt", 32'(bus.Branch_count), 32'd8);

        // Flush window ignores traffic; pushes in the resolve cycle are discarded.
        push(32'h600, 1'b0, 32'h0, 2'b00);
        step(1'b1, 32'h650, 32'h650, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h700);
        step(1'b1, 32'h660, 32'h660, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h700);
        chk("fw_bcnt", 32'(bus.Branch_count), 32'd9);
        chk("fw_mcnt", 32'(bus.Mispredict_count), 32'd3);
        idle();
        resolve(1'b1, 32'h0);
        chk("fw_addr",  bus.Branch_addr, 32'h600);
        chk("fw_bcnt2", 32'(bus.Branch_count), 32'd9);

        // Reset in the middle of a flush.
        push(32'h700, 1'b1, 32'h800, 2'b00);
        resolve(1'b0, 32'h0);
        chk("mf_flush", 32'(bus.FLUSH), 32'd1);
        pulse_reset();

        // Counter saturation.
        for (int i = 0; i < 16; i++) begin
            push(32'h20, 1'b1, 32'h10, 2'b00);
            resolve(1'b0, 32'h0);
            idle();
            idle();
        end
        chk("sat_mcnt", 32'(bus.Mispredict_count), 32'hF);
        chk("sat_bcnt", 32'(bus.Branch_count), 32'hF);
        pulse_reset();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            step(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200);
            if (i == 1500) pulse_reset();
        end
        idle();
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
